reconstrutor_caminho: RTL and testbench

Parametrised successor to the predecessor-memory path manager. It holds the "anterior" (predecessor) table written by the neighbour locator during search. On request it walks from destination back to source and streams the path out over a valid/ready interface. The path is emitted in reverse (destination→source) or forward (source→destination) order, selected at run time. It detects loops and missing predecessors, and reports path length.

---
 rtl/reconstrutor_caminho_pkg.sv | 15 +
 rtl/reconstrutor_caminho_if.sv | 40 ++++
 rtl/pilha_caminho.sv | 52 +++++
 rtl/reconstrutor_caminho.sv | 169 ++++++++++++++++
 tb/tb_reconstrutor_caminho.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reconstrutor_caminho_pkg.sv
// Shared defaults for the path reconstructor: address width and the
// path-length limit derived from the search grid.
package reconstrutor_caminho_pkg;

  localparam int unsigned ADDR_WIDTH_PADRAO = 8;
  // Square search grid; a simple path can never visit more nodes than the grid holds.
  localparam int unsigned GRADE_LADO        = 8;
  localparam int unsigned MAX_PASSOS_PADRAO = GRADE_LADO * GRADE_LADO;

  // Width needed to count 0..max_passos inclusive.
  function automatic int unsigned largura_passos(input int unsigned max_passos);
    return $clog2(max_passos + 1);
  endfunction

endpackage

// File: rtl/reconstrutor_caminho_if.sv
// Table-write, command, path-stream and status signals of the path reconstructor.
// slave is the reconstructor side, master is the requester/consumer side.
interface reconstrutor_caminho_if
  import reconstrutor_caminho_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_PADRAO,
  parameter int unsigned PASSOS_WIDTH = largura_passos(MAX_PASSOS_PADRAO)
);

  logic                    anterior_wr_en_in;
  logic [ADDR_WIDTH-1:0]   anterior_wr_addr_in;
  logic [ADDR_WIDTH-1:0]   anterior_wr_data_in;
  logic                    iniciar_in;
  logic [ADDR_WIDTH-1:0]   fonte_in;
  logic [ADDR_WIDTH-1:0]   destino_in;
  logic                    ordem_direta_in;
  logic [ADDR_WIDTH-1:0]   caminho_data_out;
  logic                    caminho_valid_out;
  logic                    caminho_ready_in;
  logic                    caminho_ultimo_out;
  logic                    ocupado_out;
  logic                    pronto_out;
  logic                    erro_out;
  logic [PASSOS_WIDTH-1:0] comprimento_out;

  modport slave (
    input  anterior_wr_en_in, anterior_wr_addr_in, anterior_wr_data_in,
    input  iniciar_in, fonte_in, destino_in, ordem_direta_in, caminho_ready_in,
    output caminho_data_out, caminho_valid_out, caminho_ultimo_out,
    output ocupado_out, pronto_out, erro_out, comprimento_out
  );

  modport master (
    output anterior_wr_en_in, anterior_wr_addr_in, anterior_wr_data_in,
    output iniciar_in, fonte_in, destino_in, ordem_direta_in, caminho_ready_in,
    input  caminho_data_out, caminho_valid_out, caminho_ultimo_out,
    input  ocupado_out, pronto_out, erro_out, comprimento_out
  );

endinterface

// File: rtl/pilha_caminho.sv
// LIFO used to reverse the walked path for source-to-destination emission.
module pilha_caminho #(
  parameter int unsigned LARGURA      = 8,
  parameter int unsigned PROFUNDIDADE = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_push,
  input  logic                                  i_pop,
  input  logic                                  i_flush,
  input  logic [LARGURA-1:0]                    i_dado,
  output logic [LARGURA-1:0]                    o_topo,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]     o_contagem
);

  localparam int unsigned CONT_W = $clog2(PROFUNDIDADE + 1);
  localparam int unsigned IDX_W  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic [CONT_W-1:0]  r_contagem;
  logic [IDX_W-1:0]   w_idx_livre;
  logic [IDX_W-1:0]   w_idx_topo;
  logic               w_cheia;
  logic               w_vazia;

  assign w_cheia     = (r_contagem == CONT_W'(PROFUNDIDADE));
  assign w_vazia     = (r_contagem == '0);
  assign w_idx_livre = IDX_W'(r_contagem);
  assign w_idx_topo  = IDX_W'(r_contagem - CONT_W'(1));

  // Occupancy: flush wins over push, push over pop.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_contagem <= '0;
    end else if (i_push && !w_cheia) begin
      r_contagem <= r_contagem + CONT_W'(1);
    end else if (i_pop && !w_vazia) begin
      r_contagem <= r_contagem - CONT_W'(1);
    end
  end

  // Storage is not reset; only the occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !w_cheia && !i_flush) begin
      r_mem[w_idx_livre] <= i_dado;
    end
  end

  assign o_topo     = w_vazia ? '0 : r_mem[w_idx_topo];
  assign o_contagem = r_contagem;

endmodule

// File: rtl/reconstrutor_caminho.sv
// Predecessor-table path reconstructor: walks destination back to source and
// streams the path in reverse or forward order, flagging loops and dead ends.
module reconstrutor_caminho
  import reconstrutor_caminho_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_PADRAO,
  parameter int unsigned MAX_PASSOS   = MAX_PASSOS_PADRAO,
  parameter int unsigned PASSOS_WIDTH = largura_passos(MAX_PASSOS)
) (
  input logic                   clk,
  input logic                   rst,
  reconstrutor_caminho_if.slave bus
);

  localparam int unsigned CONT_W = $clog2(MAX_PASSOS + 1);

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] LER        = 3'd1;
  localparam logic [2:0] ESPERA     = 3'd2;
  localparam logic [2:0] EMITIR_REV = 3'd3;
  localparam logic [2:0] EMPILHAR   = 3'd4;
  localparam logic [2:0] EMITIR_DIR = 3'd5;
  localparam logic [2:0] FIM        = 3'd6;
  localparam logic [2:0] ERRO       = 3'd7;

  logic [2:0]              r_estado;
  logic [ADDR_WIDTH-1:0]   r_fonte;
  logic [ADDR_WIDTH-1:0]   r_atual;
  logic [ADDR_WIDTH-1:0]   r_pred;
  logic                    r_direta;
  logic [PASSOS_WIDTH-1:0] r_passos;
  logic                    r_erro;
  logic [PASSOS_WIDTH-1:0] r_comprimento;
  logic [ADDR_WIDTH-1:0]   r_tabela [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   r_ram_q;

  logic                    w_na_fonte;
  logic                    w_falha;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_flush;
  logic [ADDR_WIDTH-1:0]   w_pilha_topo;
  logic [CONT_W-1:0]       w_pilha_contagem;
  logic                    w_ultimo_dir;

  assign w_na_fonte   = (r_atual == r_fonte);
  // Dead end (self-predecessor) or step budget exhausted before reaching the source.
  assign w_falha      = !w_na_fonte &&
                        ((r_ram_q == r_atual) || (r_passos == PASSOS_WIDTH'(MAX_PASSOS)));
  assign w_push       = (r_estado == EMPILHAR);
  assign w_pop        = (r_estado == EMITIR_DIR) && bus.caminho_ready_in;
  assign w_flush      = (r_estado == ERRO);
  assign w_ultimo_dir = (w_pilha_contagem == CONT_W'(1));

  // Predecessor table: writes only while idle, synchronous read of the current node.
  always_ff @(posedge clk) begin
    if ((r_estado == OCIOSO) && bus.anterior_wr_en_in) begin
      r_tabela[bus.anterior_wr_addr_in] <= bus.anterior_wr_data_in;
    end
    r_ram_q <= r_tabela[r_atual];
  end

  // Walk/emit sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado      <= OCIOSO;
      r_fonte       <= '0;
      r_atual       <= '0;
      r_pred        <= '0;
      r_direta      <= 1'b0;
      r_passos      <= '0;
      r_erro        <= 1'b0;
      r_comprimento <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (bus.iniciar_in) begin
            r_fonte  <= bus.fonte_in;
            r_atual  <= bus.destino_in;
            r_direta <= bus.ordem_direta_in;
            r_passos <= '0;
            r_erro   <= 1'b0;
            r_estado <= LER;
          end
        end
        LER: r_estado <= ESPERA;
        ESPERA: begin
          r_pred <= r_ram_q;
          if (w_falha) begin
            r_erro   <= 1'b1;
            r_estado <= ERRO;
          end else begin
            r_estado <= r_direta ? EMPILHAR : EMITIR_REV;
          end
        end
        EMITIR_REV: begin
          if (bus.caminho_ready_in) begin
            r_passos <= r_passos + PASSOS_WIDTH'(1);
            if (w_na_fonte) begin
              r_estado <= FIM;
            end else begin
              r_atual  <= r_pred;
              r_estado <= LER;
            end
          end
        end
        EMPILHAR: begin
          r_passos <= r_passos + PASSOS_WIDTH'(1);
          if (w_na_fonte) begin
            r_estado <= EMITIR_DIR;
          end else begin
            r_atual  <= r_pred;
            r_estado <= LER;
          end
        end
        EMITIR_DIR: begin
          if (bus.caminho_ready_in && w_ultimo_dir) begin
            r_estado <= FIM;
          end
        end
        FIM: begin
          r_comprimento <= r_passos;
          r_estado      <= OCIOSO;
        end
        ERRO: begin
          r_erro   <= 1'b1;
          r_estado <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  pilha_caminho #(
    .LARGURA      (ADDR_WIDTH),
    .PROFUNDIDADE (MAX_PASSOS)
  ) u_pilha (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_dado     (r_atual),
    .o_topo     (w_pilha_topo),
    .o_contagem (w_pilha_contagem)
  );

  // Stream outputs are decoded from state so they hold steady under backpressure.
  always_comb begin
    bus.caminho_valid_out  = 1'b0;
    bus.caminho_data_out   = '0;
    bus.caminho_ultimo_out = 1'b0;
    if (r_estado == EMITIR_REV) begin
      bus.caminho_valid_out  = 1'b1;
      bus.caminho_data_out   = r_atual;
      bus.caminho_ultimo_out = w_na_fonte;
    end else if (r_estado == EMITIR_DIR) begin
      bus.caminho_valid_out  = 1'b1;
      bus.caminho_data_out   = w_pilha_topo;
      bus.caminho_ultimo_out = w_ultimo_dir;
    end
  end

  assign bus.ocupado_out     = (r_estado != OCIOSO);
  assign bus.pronto_out      = (r_estado == FIM);
  assign bus.erro_out        = r_erro;
  assign bus.comprimento_out = r_comprimento;

endmodule

// File: tb/tb_reconstrutor_caminho.sv
// Randomised, self-checking bench for reconstrutor_caminho with a path-walk reference model.
module tb_reconstrutor_caminho;

  localparam int unsigned AW  = 8;
  localparam int unsigned MAX = 8;
  localparam int unsigned PW  = $clog2(MAX + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reconstrutor_caminho_if #(.ADDR_WIDTH(AW), .PASSOS_WIDTH(PW)) bus ();

  reconstrutor_caminho #(
    .ADDR_WIDTH   (AW),
    .MAX_PASSOS   (MAX),
    .PASSOS_WIDTH (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] tabela_m [256];
  logic [AW-1:0] exp_q [$];
  bit            exp_ok;
  int            comp_m;

  logic [AW-1:0] q_dado [$];
  bit            q_ult [$];
  int            n_pronto, n_instavel, n_ciclos;
  bit            estourou, erro_inicio;

  // Reference: follow predecessors from destination; success when the source is reached.
  task automatic modelo(input logic [AW-1:0] f, input logic [AW-1:0] d, input bit dir);
    logic [AW-1:0] a;
    logic [AW-1:0] lista [$];
    a = d;
    exp_ok = 1'b0;
    exp_q.delete();
    while (1) begin
      if (a == f) begin
        lista.push_back(a);
        exp_ok = 1'b1;
        break;
      end
      if (tabela_m[a] == a || lista.size() == MAX) break;
      lista.push_back(a);
      a = tabela_m[a];
    end
    if (!dir) exp_q = lista;
    else if (exp_ok) for (int i = lista.size() - 1; i >= 0; i--) exp_q.push_back(lista[i]);
  endtask

  task automatic escrever(input logic [AW-1:0] a, input logic [AW-1:0] dd);
    @(negedge clk);
    bus.anterior_wr_en_in   = 1'b1;
    bus.anterior_wr_addr_in = a;
    bus.anterior_wr_data_in = dd;
    @(negedge clk);
    bus.anterior_wr_en_in   = 1'b0;
    tabela_m[a] = dd;
  endtask

  // Launch one reconstruction and record every accepted beat until the block is idle.
  task automatic executar(input logic [AW-1:0] f, input logic [AW-1:0] d, input bit dir,
                          input int modo);
    bit            stall_prev;
    logic [AW-1:0] dado_prev;
    q_dado.delete();
    q_ult.delete();
    n_pronto = 0; n_instavel = 0; n_ciclos = 0; estourou = 1'b0;
    @(negedge clk);
    bus.fonte_in = f; bus.destino_in = d; bus.ordem_direta_in = dir; bus.iniciar_in = 1'b1;
    @(negedge clk);
    bus.iniciar_in = 1'b0;
    erro_inicio = bus.erro_out;
    stall_prev = 1'b0;
    dado_prev  = '0;
    while (bus.ocupado_out) begin
      case (modo)
        0:       bus.caminho_ready_in = 1'b1;
        1:       bus.caminho_ready_in = (n_ciclos % 2 == 0);
        default: bus.caminho_ready_in = 1'($urandom_range(0, 1));
      endcase
      if (stall_prev && (!bus.caminho_valid_out || bus.caminho_data_out != dado_prev))
        n_instavel++;
      if (bus.pronto_out) n_pronto++;
      if (bus.caminho_valid_out && bus.caminho_ready_in) begin
        q_dado.push_back(bus.caminho_data_out);
        q_ult.push_back(bus.caminho_ultimo_out);
      end
      stall_prev = bus.caminho_valid_out && !bus.caminho_ready_in;
      dado_prev  = bus.caminho_data_out;
      @(negedge clk);
      n_ciclos++;
      if (n_ciclos > 3000) begin
        estourou = 1'b1;
        break;
      end
    end
    bus.caminho_ready_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.caminho_valid_out, bus.caminho_ultimo_out, bus.ocupado_out, bus.pronto_out,
         bus.erro_out, bus.caminho_data_out, bus.comprimento_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b ult=%b ocup=%b pronto=%b erro=%b data=%0d comp=%0d",
               bus.caminho_valid_out, bus.caminho_ultimo_out, bus.ocupado_out, bus.pronto_out,
               bus.erro_out, bus.caminho_data_out, bus.comprimento_out);
    end
    rst = 1'b0;
    // Give every table entry a known random value.
    for (int i = 0; i < 256; i++) escrever(AW'(i), AW'($urandom));
  endtask

  task automatic test_reverso;
    logic [AW-1:0] esp [3];
    esp = '{8'd5, 8'd3, 8'd1};
    escrever(8'd5, 8'd3); escrever(8'd3, 8'd1); escrever(8'd1, 8'd1);
    executar(8'd1, 8'd5, 1'b0, 0);
    n_vec++;
    if (q_dado.size() != 3 || estourou) begin
      n_err++; $display("FAIL rev_count: got %0d beats required 3", q_dado.size());
    end
    for (int i = 0; i < q_dado.size() && i < 3; i++) begin
      n_vec++;
      if (q_dado[i] !== esp[i] || q_ult[i] !== (i == 2)) begin
        n_err++;
        $display("FAIL rev_beat%0d: got %0d/ult %b required %0d/ult %b", i, q_dado[i],
                 q_ult[i], esp[i], (i == 2));
      end
    end
    n_vec++;
    if (n_pronto != 1 || bus.erro_out !== 1'b0 || bus.comprimento_out !== 4'd3) begin
      n_err++;
      $display("FAIL rev_status: pronto=%0d erro=%b comp=%0d required 1/0/3", n_pronto,
               bus.erro_out, bus.comprimento_out);
    end
    n_vec++;
    if (n_ciclos != 10) begin
      n_err++; $display("FAIL rev_throughput: got %0d busy cycles required 10", n_ciclos);
    end
  endtask

  task automatic test_direto_backpressure;
    logic [AW-1:0] esp [3];
    esp = '{8'd1, 8'd3, 8'd5};
    executar(8'd1, 8'd5, 1'b1, 1);
    n_vec++;
    if (q_dado.size() != 3 || estourou || n_instavel != 0) begin
      n_err++;
      $display("FAIL dir_count: got %0d beats, %0d unstable stalls; required 3, 0",
               q_dado.size(), n_instavel);
    end
    for (int i = 0; i < q_dado.size() && i < 3; i++) begin
      n_vec++;
      if (q_dado[i] !== esp[i] || q_ult[i] !== (i == 2)) begin
        n_err++;
        $display("FAIL dir_beat%0d: got %0d/ult %b required %0d/ult %b", i, q_dado[i],
                 q_ult[i], esp[i], (i == 2));
      end
    end
    n_vec++;
    if (n_pronto != 1 || bus.erro_out !== 1'b0 || bus.comprimento_out !== 4'd3) begin
      n_err++;
      $display("FAIL dir_status: pronto=%0d erro=%b comp=%0d required 1/0/3", n_pronto,
               bus.erro_out, bus.comprimento_out);
    end
  endtask

  task automatic test_fonte_destino;
    executar(8'd7, 8'd7, 1'b0, 0);
    n_vec++;
    if (q_dado.size() != 1 || q_dado[0] !== 8'd7 || q_ult[0] !== 1'b1 || n_pronto != 1 ||
        bus.comprimento_out !== 4'd1) begin
      n_err++;
      $display("FAIL same_node: beats=%0d first=%0d pronto=%0d comp=%0d required 1/7/1/1",
               q_dado.size(), (q_dado.size() > 0) ? q_dado[0] : 8'd0, n_pronto,
               bus.comprimento_out);
    end
  endtask

  task automatic test_sem_predecessor;
    escrever(8'd9, 8'd9);
    executar(8'd2, 8'd9, 1'b0, 0);
    n_vec++;
    if (q_dado.size() != 0 || n_pronto != 0 || bus.erro_out !== 1'b1 ||
        bus.comprimento_out !== 4'd1 || estourou) begin
      n_err++;
      $display("FAIL no_pred: beats=%0d pronto=%0d erro=%b comp=%0d required 0/0/1/1",
               q_dado.size(), n_pronto, bus.erro_out, bus.comprimento_out);
    end
    executar(8'd9, 8'd9, 1'b0, 0);
    n_vec++;
    if (erro_inicio !== 1'b0 || bus.erro_out !== 1'b0 || n_pronto != 1) begin
      n_err++;
      $display("FAIL erro_clear: erro after start=%b at end=%b pronto=%0d required 0/0/1",
               erro_inicio, bus.erro_out, n_pronto);
    end
  endtask

  task automatic test_loop;
    logic [AW-1:0] esp [3];
    esp = '{8'd1, 8'd3, 8'd5};
    escrever(8'd4, 8'd6); escrever(8'd6, 8'd4);
    executar(8'd0, 8'd4, 1'b1, 0);
    n_vec++;
    if (q_dado.size() != 0 || n_pronto != 0 || bus.erro_out !== 1'b1) begin
      n_err++;
      $display("FAIL loop_err: beats=%0d pronto=%0d erro=%b required 0/0/1", q_dado.size(),
               n_pronto, bus.erro_out);
    end
    // Eight 3-cycle pushes, one more read/wait, then the error cycle.
    n_vec++;
    if (n_ciclos != 3 * MAX + 3) begin
      n_err++; $display("FAIL loop_cycles: got %0d required %0d", n_ciclos, 3 * MAX + 3);
    end
    // A leftover stack would corrupt the next forward path.
    executar(8'd1, 8'd5, 1'b1, 0);
    n_vec++;
    if (q_dado.size() != 3) begin
      n_err++; $display("FAIL loop_flush_count: got %0d beats required 3", q_dado.size());
    end
    for (int i = 0; i < q_dado.size() && i < 3; i++) begin
      n_vec++;
      if (q_dado[i] !== esp[i] || q_ult[i] !== (i == 2)) begin
        n_err++;
        $display("FAIL loop_flush_beat%0d: got %0d/ult %b required %0d/ult %b", i, q_dado[i],
                 q_ult[i], esp[i], (i == 2));
      end
    end
  endtask

  task automatic test_reset_meio;
    int espera;
    escrever(8'd14, 8'd13); escrever(8'd13, 8'd12);
    escrever(8'd12, 8'd11); escrever(8'd11, 8'd10);
    @(negedge clk);
    bus.fonte_in = 8'd10; bus.destino_in = 8'd14; bus.ordem_direta_in = 1'b1;
    bus.iniciar_in = 1'b1;
    @(negedge clk);
    bus.iniciar_in = 1'b0;
    @(negedge clk);
    // Busy write and busy start; both must be ignored.
    bus.anterior_wr_en_in = 1'b1; bus.anterior_wr_addr_in = 8'd13; bus.anterior_wr_data_in = 8'd99;
    bus.iniciar_in = 1'b1; bus.fonte_in = 8'd0; bus.destino_in = 8'd0; bus.ordem_direta_in = 1'b0;
    @(negedge clk);
    bus.anterior_wr_en_in = 1'b0; bus.iniciar_in = 1'b0;
    espera = 0;
    while (!bus.caminho_valid_out && espera < 100) begin
      @(negedge clk);
      espera++;
    end
    n_vec++;
    if (espera >= 100 || bus.caminho_data_out !== 8'd10 || bus.caminho_ultimo_out !== 1'b0) begin
      n_err++;
      $display("FAIL busy_first_beat: valid=%b data=%0d ult=%b required 1/10/0",
               bus.caminho_valid_out, bus.caminho_data_out, bus.caminho_ultimo_out);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({bus.caminho_valid_out, bus.caminho_ultimo_out, bus.ocupado_out, bus.pronto_out,
         bus.erro_out, bus.caminho_data_out, bus.comprimento_out} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: valid=%b ocup=%b pronto=%b erro=%b data=%0d comp=%0d",
               bus.caminho_valid_out, bus.ocupado_out, bus.pronto_out, bus.erro_out,
               bus.caminho_data_out, bus.comprimento_out);
    end
    executar(8'd10, 8'd14, 1'b1, 0);
    n_vec++;
    if (q_dado.size() != 5 || n_pronto != 1 || bus.comprimento_out !== 4'd5) begin
      n_err++;
      $display("FAIL after_reset_run: beats=%0d pronto=%0d comp=%0d required 5/1/5",
               q_dado.size(), n_pronto, bus.comprimento_out);
    end
    for (int i = 0; i < q_dado.size() && i < 5; i++) begin
      n_vec++;
      if (q_dado[i] !== AW'(10 + i)) begin
        n_err++; $display("FAIL after_reset_beat%0d: got %0d required %0d", i, q_dado[i], 10 + i);
      end
    end
    comp_m = 5;
  endtask

  task automatic test_aleatorio;
    logic [AW-1:0] f, d;
    bit            dir;
    for (int it = 0; it < 24; it++) begin
      for (int n = 0; n < 12; n++) escrever(AW'(n), AW'($urandom_range(0, 11)));
      f   = AW'($urandom_range(0, 11));
      d   = AW'($urandom_range(0, 11));
      dir = 1'($urandom_range(0, 1));
      modelo(f, d, dir);
      executar(f, d, dir, 2);
      if (exp_ok) comp_m = exp_q.size();
      n_vec++;
      if (q_dado.size() != exp_q.size() || estourou || n_instavel != 0) begin
        n_err++;
        $display("FAIL rnd%0d_count: got %0d beats (%0d unstable) required %0d", it,
                 q_dado.size(), n_instavel, exp_q.size());
      end
      for (int i = 0; i < q_dado.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (q_dado[i] !== exp_q[i] || q_ult[i] !== (exp_ok && i == exp_q.size() - 1)) begin
          n_err++;
          $display("FAIL rnd%0d_beat%0d: got %0d/ult %b required %0d/ult %b", it, i,
                   q_dado[i], q_ult[i], exp_q[i], (exp_ok && i == exp_q.size() - 1));
        end
      end
      n_vec++;
      if (n_pronto != int'(exp_ok) || bus.erro_out !== !exp_ok ||
          bus.comprimento_out !== PW'(comp_m)) begin
        n_err++;
        $display("FAIL rnd%0d_status: pronto=%0d erro=%b comp=%0d required %0d/%b/%0d", it,
                 n_pronto, bus.erro_out, bus.comprimento_out, exp_ok, !exp_ok, comp_m);
      end
    end
  endtask

  initial begin
    bus.anterior_wr_en_in   = 1'b0;
    bus.anterior_wr_addr_in = '0;
    bus.anterior_wr_data_in = '0;
    bus.iniciar_in          = 1'b0;
    bus.fonte_in            = '0;
    bus.destino_in          = '0;
    bus.ordem_direta_in     = 1'b0;
    bus.caminho_ready_in    = 1'b0;
    comp_m                  = 0;
    test_reset();
    test_reverso();
    test_direto_backpressure();
    test_fonte_destino();
    test_sem_predecessor();
    test_loop();
    test_reset_meio();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
